// File: rtl/sum_stage_pkg.sv
// Shared widths and payload types for the PE row sum stage.
package sum_stage_pkg;

  localparam int unsigned PE_ROWS = 4;
  localparam int unsigned D_WD    = 8;
  localparam int unsigned PSUM_WD = 16;
  localparam int unsigned ASUM_WD = 12;

  typedef enum logic {
    D16 = 1'b0,
    D8  = 1'b1
  } psum_mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ss_state_e;

  typedef struct packed {
    logic       first;
    logic       last;
    psum_mode_e psum_mode;
  } SSctl;

  // Post-processing control forwarded untouched to the next stage.
  typedef struct packed {
    logic       relu;
    logic [2:0] shift;
    logic [3:0] tag;
  } PPctl;

  typedef struct packed {
    SSctl ssctl;
    PPctl ssppctl;
  } MSpipe;

  typedef struct packed {
    logic signed [PSUM_WD-1:0] Psum_MS;
    logic signed [ASUM_WD-1:0] Sum_MS;
  } MSout;

  typedef struct packed {
    logic signed [PSUM_WD-1:0] Psum_SS;
  } SSout;

endpackage

// File: rtl/sum_stage_satacc.sv
// SatAcc: one-row signed add with clamp to the D8 or D16 partial-sum range.
module SatAcc
  import sum_stage_pkg::*;
#(
  parameter int unsigned DWD     = D_WD,
  parameter int unsigned PSUMDWD = PSUM_WD
) (
  input  logic signed [PSUMDWD-1:0] i_base,
  input  logic signed [PSUMDWD-1:0] i_addend,
  input  psum_mode_e                i_mode,
  output logic signed [PSUMDWD-1:0] o_sum_c
);

  localparam int unsigned WW = PSUMDWD + 1;

  logic signed [WW-1:0] w_wide;
  logic signed [WW-1:0] w_max;
  logic signed [WW-1:0] w_min;

  // One guard bit is enough to hold any sum of two PSUMDWD operands.
  always_comb begin
    w_wide = $signed({i_base[PSUMDWD-1], i_base}) + $signed({i_addend[PSUMDWD-1], i_addend});
    if (i_mode == D8) begin
      w_max = $signed({{(WW-DWD+1){1'b0}}, {(DWD-1){1'b1}}});
      w_min = $signed({{(WW-DWD+1){1'b1}}, {(DWD-1){1'b0}}});
    end else begin
      w_max = $signed({2'b00, {(PSUMDWD-1){1'b1}}});
      w_min = $signed({2'b11, {(PSUMDWD-1){1'b0}}});
    end
    if (w_wide > w_max) begin
      o_sum_c = w_max[PSUMDWD-1:0];
    end else if (w_wide < w_min) begin
      o_sum_c = w_min[PSUMDWD-1:0];
    end else begin
      o_sum_c = w_wide[PSUMDWD-1:0];
    end
  end

endmodule

// File: rtl/sum_stage.sv
// PE row sum stage: accumulates multiply-stage beats per row and hands one
// saturated partial sum per job to post-processing over the SS handshake.
module sum_stage
  import sum_stage_pkg::*;
#(
  parameter int unsigned PEROW   = PE_ROWS,
  parameter int unsigned DWD     = D_WD,
  parameter int unsigned PSUMDWD = PSUM_WD,
  parameter int unsigned ASUMDWD = ASUM_WD
) (
  input  logic  i_clk,
  input  logic  i_rstn,
  input  logic  MS_rdy,
  output logic  MS_ack,
  input  MSpipe i_MSpipe,
  input  MSout  i_data [PEROW],
  output logic  SS_rdy,
  input  logic  SS_ack,
  output SSout  o_data [PEROW],
  output PPctl  o_SSpipe_SS
);

  ss_state_e r_state;
  ss_state_e w_state_nxt;
  PPctl      r_pp;
  logic      w_ms_fire;
  logic      w_last_fire;
  logic      w_ss_fire;

  assign w_ms_fire   = MS_rdy && MS_ack;
  assign w_last_fire = w_ms_fire && i_MSpipe.ssctl.last;
  assign w_ss_fire   = SS_rdy && SS_ack;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= ST_EMPTY;
    end else if (w_ms_fire || w_ss_fire) begin
      r_state <= w_state_nxt;
    end
  end

  // A last beat refills the output register even as the old result leaves.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_last_fire) w_state_nxt = ST_FULL;
      ST_FULL: begin
        if (w_last_fire)    w_state_nxt = ST_FULL;
        else if (w_ss_fire) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Only last beats wait on the output register; middle beats never stall.
  always_comb begin
    SS_rdy = 1'b0;
    MS_ack = 1'b0;
    SS_rdy = (r_state == ST_FULL);
    MS_ack = !i_MSpipe.ssctl.last || (r_state == ST_EMPTY) || SS_ack;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_pp <= '0;
    end else if (w_last_fire) begin
      r_pp <= i_MSpipe.ssppctl;
    end
  end

  assign o_SSpipe_SS = r_pp;

  for (genvar g = 0; g < int'(PEROW); g++) begin : g_row
    logic signed [PSUMDWD-1:0] r_acc;
    logic signed [PSUMDWD-1:0] r_out;
    logic signed [PSUMDWD-1:0] w_base;
    logic signed [PSUMDWD-1:0] w_addend;
    logic signed [PSUMDWD-1:0] w_sat;

    // Incoming Psum only seeds a job; later beats build on the row's own acc.
    assign w_base   = i_MSpipe.ssctl.first ? i_data[g].Psum_MS : r_acc;
    assign w_addend = {{(PSUMDWD-ASUMDWD){i_data[g].Sum_MS[ASUMDWD-1]}}, i_data[g].Sum_MS};

    SatAcc #(
      .DWD     (DWD),
      .PSUMDWD (PSUMDWD)
    ) u_satacc (
      .i_base   (w_base),
      .i_addend (w_addend),
      .i_mode   (i_MSpipe.ssctl.psum_mode),
      .o_sum_c  (w_sat)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        r_acc <= '0;
      end else if (w_ms_fire) begin
        r_acc <= w_sat;
      end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        r_out <= '0;
      end else if (w_last_fire) begin
        r_out <= w_sat;
      end
    end

    assign o_data[g].Psum_SS = r_out;
  end

endmodule

// File: tb/tb_sum_stage.sv
// Directed self-checking bench for sum_stage: vector table plus multi-cycle sequences.
module tb_sum_stage;
  import sum_stage_pkg::*;

  localparam int unsigned NR = 4;

  typedef struct {
    logic       mode;
    logic [7:0] pp;
    int         psum [4];
    int         sum  [4];
    int         exp  [4];
  } vec_t;

  logic  i_clk;
  logic  i_rstn;
  logic  MS_rdy;
  logic  MS_ack;
  MSpipe i_MSpipe;
  MSout  i_data [NR];
  logic  SS_rdy;
  logic  SS_ack;
  SSout  o_data [NR];
  PPctl  o_SSpipe_SS;

  int n_chk;
  int n_fail;

  sum_stage #(
    .PEROW   (NR),
    .DWD     (8),
    .PSUMDWD (16),
    .ASUMDWD (12)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .MS_rdy      (MS_rdy),
    .MS_ack      (MS_ack),
    .i_MSpipe    (i_MSpipe),
    .i_data      (i_data),
    .SS_rdy      (SS_rdy),
    .SS_ack      (SS_ack),
    .o_data      (o_data),
    .o_SSpipe_SS (o_SSpipe_SS)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic beat(input logic first, input logic last, input logic mode, input logic [7:0] pp,
                      input int p [4], input int s [4]);
    MS_rdy                   = 1'b1;
    i_MSpipe.ssctl.first     = first;
    i_MSpipe.ssctl.last      = last;
    i_MSpipe.ssctl.psum_mode = psum_mode_e'(mode);
    i_MSpipe.ssppctl         = PPctl'(pp);
    for (int r = 0; r < 4; r++) begin
      i_data[r].Psum_MS = 16'(p[r]);
      i_data[r].Sum_MS  = 12'(s[r]);
    end
  endtask

  task automatic chk_out(input string name, input int e [4], input logic [7:0] epp);
    chk({name, ".rdy"}, {31'b0, SS_rdy}, 1);
    for (int r = 0; r < 4; r++) chk($sformatf("%s.row%0d", name, r), o_data[r].Psum_SS, e[r]);
    chk({name, ".pp"}, {24'b0, o_SSpipe_SS}, {24'b0, epp});
  endtask

  function automatic vec_t mkv(input logic m, input logic [7:0] pp,
                               input int p0, input int p1, input int p2, input int p3,
                               input int s0, input int s1, input int s2, input int s3,
                               input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.mode = m;
    v.pp   = pp;
    v.psum = '{p0, p1, p2, p3};
    v.sum  = '{s0, s1, s2, s3};
    v.exp  = '{e0, e1, e2, e3};
    return v;
  endfunction

  initial begin
    vec_t vecs [5];
    int   p [4];
    int   s [4];
    int   e [4];
    int   a_exp [4];

    n_chk  = 0;
    n_fail = 0;
    i_rstn = 1'b0;
    MS_rdy = 1'b0;
    SS_ack = 1'b0;
    i_MSpipe = '0;
    for (int r = 0; r < 4; r++) i_data[r] = '0;

    // single-beat jobs, mode 0 = D16, 1 = D8
    vecs[0] = mkv(1'b0, 8'h5A, 100, 0, -5, 32760,   -30, 0, 5, 2047,       70, 0, 0, 32767);
    vecs[1] = mkv(1'b1, 8'hA5, -120, 100, 0, 127,   -50, 27, 200, -1,      -128, 127, 127, 126);
    vecs[2] = mkv(1'b0, 8'h3C, -32768, -32000, 1000, 0, -1, -2048, -2048, 2047, -32768, -32768, -1048, 2047);
    vecs[3] = mkv(1'b1, 8'h01, 0, -128, 50, -200,   0, -1, -60, 100,       0, -128, -10, -100);
    vecs[4] = mkv(1'b0, 8'hFF, 32767, -1, 0, 12345, 1, 1, -2048, -345,     32767, 0, -2048, 12000);

    tick();
    tick();
    chk("reset.rdy", {31'b0, SS_rdy}, 0);
    for (int r = 0; r < 4; r++) chk($sformatf("reset.row%0d", r), o_data[r].Psum_SS, 0);
    chk("reset.pp", {24'b0, o_SSpipe_SS}, 0);
    i_rstn = 1'b1;
    tick();

    // back-to-back single-beat jobs with downstream always ready
    SS_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, 1'b1, vecs[i].mode, vecs[i].pp, vecs[i].psum, vecs[i].sum);
      #1;
      chk($sformatf("vec%0d.ms_ack", i), {31'b0, MS_ack}, 1);
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].exp, vecs[i].pp);
    end
    MS_rdy = 1'b0;
    tick();
    chk("drain.rdy", {31'b0, SS_rdy}, 0);

    // three-beat job: exactly one result
    p = '{10, 0, -10, 100};
    s = '{5, 1, 0, -100};
    beat(1'b1, 1'b0, 1'b0, 8'h66, p, s);
    tick();
    chk("multi.b1.rdy", {31'b0, SS_rdy}, 0);
    s = '{7, 1, 0, 0};
    beat(1'b0, 1'b0, 1'b0, 8'h66, p, s);
    tick();
    chk("multi.b2.rdy", {31'b0, SS_rdy}, 0);
    s = '{-2, 1, -3, 5};
    beat(1'b0, 1'b1, 1'b0, 8'h67, p, s);
    tick();
    e = '{20, 3, -13, 5};
    chk_out("multi", e, 8'h67);
    MS_rdy = 1'b0;
    tick();
    chk("multi.once.rdy", {31'b0, SS_rdy}, 0);

    // backpressure: job A blocked, job B accumulates then stalls on its last beat
    SS_ack = 1'b0;
    p = '{1, 2, 3, 4};
    s = '{0, 0, 0, 0};
    beat(1'b1, 1'b1, 1'b0, 8'h11, p, s);
    tick();
    a_exp = '{1, 2, 3, 4};
    chk_out("bpA", a_exp, 8'h11);
    p = '{100, 200, 300, 400};
    s = '{1, 1, 1, 1};
    beat(1'b1, 1'b0, 1'b0, 8'h20, p, s);
    #1;
    chk("bpB.b1.ms_ack", {31'b0, MS_ack}, 1);
    tick();
    chk_out("bpB.b1.holdA", a_exp, 8'h11);
    s = '{2, 2, 2, 2};
    beat(1'b0, 1'b0, 1'b0, 8'h21, p, s);
    tick();
    chk_out("bpB.b2.holdA", a_exp, 8'h11);
    s = '{3, 3, 3, 3};
    beat(1'b0, 1'b1, 1'b0, 8'h22, p, s);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bpB.stall%0d.ms_ack", c), {31'b0, MS_ack}, 0);
      tick();
      chk_out($sformatf("bpB.stall%0d.holdA", c), a_exp, 8'h11);
    end
    SS_ack = 1'b1;
    #1;
    chk("bpB.release.ms_ack", {31'b0, MS_ack}, 1);
    tick();
    e = '{106, 206, 306, 406};
    chk_out("bpB", e, 8'h22);
    MS_rdy = 1'b0;
    tick();
    chk("bpB.drain.rdy", {31'b0, SS_rdy}, 0);

    // reset mid-job with a result pending
    SS_ack = 1'b0;
    p = '{1, 1, 1, 1};
    s = '{0, 0, 0, 0};
    beat(1'b1, 1'b1, 1'b0, 8'h77, p, s);
    tick();
    chk("rst.pending.rdy", {31'b0, SS_rdy}, 1);
    p = '{500, 500, 500, 500};
    s = '{1, 1, 1, 1};
    beat(1'b1, 1'b0, 1'b0, 8'h78, p, s);
    tick();
    beat(1'b0, 1'b0, 1'b0, 8'h78, p, s);
    tick();
    i_rstn = 1'b0;
    #1;
    chk("rst.rdy", {31'b0, SS_rdy}, 0);
    for (int r = 0; r < 4; r++) chk($sformatf("rst.row%0d", r), o_data[r].Psum_SS, 0);
    chk("rst.pp", {24'b0, o_SSpipe_SS}, 0);
    MS_rdy = 1'b0;
    tick();
    i_rstn = 1'b1;
    SS_ack = 1'b1;
    // non-first last beat exposes any accumulator residue
    p = '{999, 999, 999, 999};
    s = '{5, -5, 0, 1};
    beat(1'b0, 1'b1, 1'b0, 8'h44, p, s);
    tick();
    e = '{5, -5, 0, 1};
    chk_out("rst.residue", e, 8'h44);
    p = '{7, 7, 7, 7};
    s = '{1, 2, 3, 4};
    beat(1'b1, 1'b1, 1'b0, 8'h55, p, s);
    tick();
    e = '{8, 9, 10, 11};
    chk_out("rst.fresh", e, 8'h55);
    MS_rdy = 1'b0;
    tick();
    chk("rst.drain.rdy", {31'b0, SS_rdy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
